uart_frame_bridge: RTL
======================

UART_FRAME_BRIDGE -- requirements
Module: uart_frame_bridge

Interface
REQ-001 Parameter: DBITS, 8, bits per UART character.
REQ-002 Parameter: FRAME_BYTES, 16, characters per frame (legal 2..64); FW = FRAME_BYTES*DBITS.
REQ-003 Parameter: TIMEOUT_CYCLES, 1_000_000, idle clk cycles before a partial frame is dropped; 0 disables the timeout.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 clr  in  1  synchronous clear, active-high.
REQ-007 rx_data  in  DBITS  received character.
REQ-008 rx_valid  in  1  one-cycle strobe per received character.
REQ-009 din  out  FW  assembled frame to coprocessor.
REQ-010 din_valid  out  1  frame available.
REQ-011 din_ready  in  1  coprocessor accepts frame.
REQ-012 dout  in  FW  result frame from coprocessor.
REQ-013 dout_valid  in  1  result frame available.
REQ-014 dout_ready  out  1  bridge accepts result frame.
REQ-015 tx_data  out  DBITS  character to UART transmitter.
REQ-016 tx_valid  out  1  character available.
REQ-017 tx_ready  in  1  transmitter accepts character.
REQ-018 rx_count  out  clog2(FRAME_BYTES+1)  characters held in the partial frame.
REQ-019 overrun  out  1  sticky: a complete frame was dropped.
REQ-020 timeout  out  1  one-cycle pulse: a partial frame was dropped.

Function
REQ-021 Character k of a frame (arrival order, 0-based) SHALL be stored at assembly bits [k*DBITS +: DBITS].
REQ-022 rx_valid SHALL increment rx_count; on character FRAME_BYTES-1, rx_count SHALL return to 0 on the same edge.
REQ-023 A completed frame SHALL be moved into a separate output register, and din_valid SHALL be 1 on the cycle after the last character's strobe.
REQ-024 din and din_valid SHALL remain stable while din_valid=1 and din_ready=0; a transfer occurs when both are 1.
REQ-025 Assembly of the next frame SHALL continue while the output register is full.
REQ-026 If a frame completes while the output register is full and din_ready=0, the frame SHALL be discarded and overrun set; overrun SHALL stay set until clr or reset.
REQ-027 If a frame completes on the same cycle as a transfer, the new frame SHALL load and din_valid SHALL stay 1 without a gap.
REQ-028 When TIMEOUT_CYCLES>0 and rx_count!=0, the idle counter SHALL count cycles with no rx_valid and clear on every rx_valid.
REQ-029 On reaching TIMEOUT_CYCLES idle cycles, rx_count SHALL go to 0, the partial frame SHALL be discarded, and timeout SHALL pulse for 1 cycle.
REQ-030 An rx_valid on the expiry cycle SHALL take priority: the character is stored and no timeout occurs.
REQ-031 The TX FSM SHALL have states IDLE and SEND; in IDLE, dout_ready=1 and tx_valid=0.
REQ-032 In IDLE, when dout_valid=1, the FSM SHALL capture dout, set the index to 0, and enter SEND; tx_valid SHALL be 1 on the next cycle.
REQ-033 In SEND, dout_ready=0, tx_valid=1, and tx_data SHALL be the captured bits [idx*DBITS +: DBITS].
REQ-034 In SEND, when tx_ready=1, the index SHALL advance; when byte FRAME_BYTES-1 is accepted, the FSM SHALL return to IDLE.
REQ-035 tx_data SHALL hold while tx_valid=1 and tx_ready=0.
REQ-036 The RX and TX paths SHALL operate concurrently and independently.

Reset
REQ-037 rst_n=0 SHALL immediately force: rx_count=0, din_valid=0, din=0, overrun=0, timeout=0, idle counter=0, FSM=IDLE, tx_valid=0, tx_data=0, dout_ready=1.
REQ-038 clr=1 SHALL produce the REQ-037 state on the next edge and take priority over all other inputs.
REQ-039 Reset or clr asserted mid-frame or mid-SEND SHALL discard all partial and buffered data with no further tx_valid.

Verification
REQ-040 16 strobes with bytes 0x00..0x0F, din_ready=1 -> din_valid the cycle after the 16th strobe; din = 0x0F0E...0100; rx_count=0.
REQ-041 din_ready=0; 32 strobes -> first frame held stable; second frame assembled and dropped; overrun=1; rx_count=0.
REQ-042 TIMEOUT_CYCLES=8; 3 strobes, then 8 idle cycles -> timeout pulses once; rx_count 3->0; the next 16 bytes form a clean frame.
REQ-043 dout=0x0F..00 with one dout_valid pulse; tx_ready toggling every other cycle -> tx_data 0x00..0x0F in order; dout_ready=0 until the 16th accept, then 1.
REQ-044 rst_n pulsed low after 5 received bytes and during SEND byte 7 -> all outputs at REQ-037 values; no stale byte is emitted afterwards.
REQ-045 Frame completion coincident with a din transfer -> din_valid stays 1 and the second frame is presented on the next cycle.

Source files
------------

// File: rtl/uart_frame_bridge.sv
// -----------------------------------------------------------------------------
// uart_frame_bridge
//
// Purpose
//   Bridges a character-oriented UART link to a frame-oriented coprocessor.
//   RX path: gathers FRAME_BYTES characters into one wide frame and offers it
//   on a valid/ready port, with overrun flagging and an idle timeout that
//   drops stale partial frames.
//   TX path: accepts one wide result frame and serialises it, character by
//   character, onto a valid/ready transmitter port.
//   The two paths share only clk, rst_n and clr.
//
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   clr         in   synchronous active-high clear, highest priority
//   rx_data     in   [DBITS]   received character
//   rx_valid    in   one-cycle strobe per received character
//   din         out  [FW]      assembled frame to coprocessor
//   din_valid   out  frame available
//   din_ready   in   coprocessor accepts frame
//   dout        in   [FW]      result frame from coprocessor
//   dout_valid  in   result frame available
//   dout_ready  out  bridge accepts result frame
//   tx_data     out  [DBITS]   character to UART transmitter
//   tx_valid    out  character available
//   tx_ready    in   transmitter accepts character
//   rx_count    out  [CW]      characters held in the partial frame
//   overrun     out  sticky: a complete frame was dropped
//   timeout     out  one-cycle pulse: a partial frame was dropped
// -----------------------------------------------------------------------------
module uart_frame_bridge #(
   parameter  int DBITS          = 8,
   parameter  int FRAME_BYTES    = 16,
   parameter  int TIMEOUT_CYCLES = 1_000_000,
   localparam int FW             = FRAME_BYTES * DBITS,
   localparam int CW             = $clog2(FRAME_BYTES + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [DBITS-1:0] rx_data,
   input  logic             rx_valid,
   output logic [FW-1:0]    din,
   output logic             din_valid,
   input  logic             din_ready,
   input  logic [FW-1:0]    dout,
   input  logic             dout_valid,
   output logic             dout_ready,
   output logic [DBITS-1:0] tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic [CW-1:0]    rx_count,
   output logic             overrun,
   output logic             timeout
);

   // ---------------------------------------------------------------------------
   // Derived constants
   // ---------------------------------------------------------------------------
   localparam int IW          = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
   localparam bit TO_EN       = (TIMEOUT_CYCLES > 0);
   localparam int TW          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int TO_LAST_INT = TO_EN ? (TIMEOUT_CYCLES - 1) : 0;

   localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_BYTES - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BYTES - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TO_LAST_INT);

   // ---------------------------------------------------------------------------
   // RX path state
   // ---------------------------------------------------------------------------
   logic [FW-1:0] asm_q,       asm_d;        // frame under assembly
   logic [CW-1:0] rx_count_q,  rx_count_d;
   logic [TW-1:0] idle_q,      idle_d;       // idle cycles since last character
   logic [FW-1:0] din_q,       din_d;        // output holding register
   logic          din_valid_q, din_valid_d;
   logic          overrun_q,   overrun_d;
   logic          timeout_q,   timeout_d;
   logic          frame_done;

   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path can
      // leave it unassigned, which would otherwise infer a latch.
      asm_d       = asm_q;
      rx_count_d  = rx_count_q;
      idle_d      = idle_q;
      din_d       = din_q;
      din_valid_d = din_valid_q;
      overrun_d   = overrun_q;
      timeout_d   = 1'b0;
      frame_done  = 1'b0;

      if (clr) begin
         asm_d       = '0;
         rx_count_d  = '0;
         idle_d      = '0;
         din_d       = '0;
         din_valid_d = 1'b0;
         overrun_d   = 1'b0;
      end else begin
         // Character capture. A strobe always wins over timeout expiry, so a
         // character arriving on the expiry cycle extends the frame instead.
         if (rx_valid) begin
            asm_d[int'(rx_count_q) * DBITS +: DBITS] = rx_data;
            idle_d = '0;
            if (rx_count_q == LAST_CNT) begin
               rx_count_d = '0;
               frame_done = 1'b1;
            end else begin
               rx_count_d = rx_count_q + 1'b1;
            end
         end else if (TO_EN && (rx_count_q != '0)) begin
            if (idle_q == TO_LAST) begin
               // Stale partial frame: drop it and announce with a pulse.
               asm_d      = '0;
               rx_count_d = '0;
               idle_d     = '0;
               timeout_d  = 1'b1;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end

         // Output register. A completed frame may load if the register is
         // empty or is being emptied this very cycle (back-to-back, no gap);
         // otherwise the new frame is lost and overrun sticks.
         if (frame_done) begin
            if (!din_valid_q || din_ready) begin
               din_d       = asm_d;
               din_valid_d = 1'b1;
            end else begin
               overrun_d = 1'b1;
            end
         end else if (din_valid_q && din_ready) begin
            din_valid_d = 1'b0;
         end
      end
   end

   // NOTE: the frame buffers are reset along with the control state because
   // din must read as zero in reset; stale assembly data is never exposed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         asm_q       <= '0;
         rx_count_q  <= '0;
         idle_q      <= '0;
         din_q       <= '0;
         din_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values of its peers.
         asm_q       <= asm_d;
         rx_count_q  <= rx_count_d;
         idle_q      <= idle_d;
         din_q       <= din_d;
         din_valid_q <= din_valid_d;
         overrun_q   <= overrun_d;
         timeout_q   <= timeout_d;
      end
   end

   assign din       = din_q;
   assign din_valid = din_valid_q;
   assign rx_count  = rx_count_q;
   assign overrun   = overrun_q;
   assign timeout   = timeout_q;

   // ---------------------------------------------------------------------------
   // TX path: two-state serialiser with registered outputs
   // ---------------------------------------------------------------------------
   typedef enum logic {
      IDLE,
      SEND
   } tx_state_t;

   tx_state_t        state_q;
   logic [FW-1:0]    cap_q;          // captured result frame
   logic [IW-1:0]    idx_q;          // index of character being offered
   logic [DBITS-1:0] tx_data_q;
   logic             tx_valid_q;
   logic             dout_ready_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cap_q        <= '0;
         idx_q        <= '0;
         tx_data_q    <= '0;
         tx_valid_q   <= 1'b0;
         dout_ready_q <= 1'b1;
      end else if (clr) begin
         state_q      <= IDLE;
         cap_q        <= '0;
         idx_q        <= '0;
         tx_data_q    <= '0;
         tx_valid_q   <= 1'b0;
         dout_ready_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (dout_valid) begin
                  cap_q        <= dout;
                  idx_q        <= '0;
                  tx_data_q    <= dout[DBITS-1:0];
                  tx_valid_q   <= 1'b1;
                  dout_ready_q <= 1'b0;
                  state_q      <= SEND;
               end
            end
            SEND: begin
               // tx_data only moves on an accepted character, so it holds
               // steady through any transmitter stall.
               if (tx_ready) begin
                  if (idx_q == LAST_IDX) begin
                     tx_valid_q   <= 1'b0;
                     dout_ready_q <= 1'b1;
                     state_q      <= IDLE;
                  end else begin
                     idx_q     <= idx_q + 1'b1;
                     tx_data_q <= cap_q[(int'(idx_q) + 1) * DBITS +: DBITS];
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign tx_data    = tx_data_q;
   assign tx_valid   = tx_valid_q;
   assign dout_ready = dout_ready_q;

endmodule
